// File: rtl/axicb_slv_wr_arbiter_if.sv
// rtl/axicb_slv_wr_arbiter_if.sv - master-side and slave-side write channels of one slave write arbiter
// Modport slave is the arbiter's view; modport master is the environment's view.
interface axicb_slv_wr_arbiter_if #(
  parameter int MST_NB     = 4,
  parameter int AWCH_W     = 8,
  parameter int WCH_W      = 8,
  parameter int BCH_W      = 10,
  parameter int OSTD_DEPTH = 4
);
  logic [MST_NB-1:0]        i_awvalid;
  logic [MST_NB-1:0]        i_awready;
  logic [MST_NB*AWCH_W-1:0] i_awch;
  logic [MST_NB-1:0]        i_wvalid;
  logic [MST_NB-1:0]        i_wlast;
  logic [MST_NB-1:0]        i_wready;
  logic [MST_NB*WCH_W-1:0]  i_wch;
  logic [MST_NB-1:0]        i_bvalid;
  logic [MST_NB-1:0]        i_bready;
  logic [BCH_W-1:0]         i_bch;

  logic                     o_awvalid;
  logic                     o_awready;
  logic [AWCH_W-1:0]        o_awch;
  logic                     o_wvalid;
  logic                     o_wready;
  logic                     o_wlast;
  logic [WCH_W-1:0]         o_wch;
  logic                     o_bvalid;
  logic                     o_bready;
  logic [BCH_W-1:0]         o_bch;

  logic [$clog2(OSTD_DEPTH):0] o_ostd;

  modport slave (
    input  i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, i_bready,
    input  o_awready, o_wready, o_bvalid, o_bch,
    output i_awready, i_wready, i_bvalid, i_bch,
    output o_awvalid, o_awch, o_wvalid, o_wlast, o_wch, o_bready, o_ostd
  );

  modport master (
    output i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, i_bready,
    output o_awready, o_wready, o_bvalid, o_bch,
    input  i_awready, i_wready, i_bvalid, i_bch,
    input  o_awvalid, o_awch, o_wvalid, o_wlast, o_wch, o_bready, o_ostd
  );
endinterface

// File: rtl/axicb_slv_wr_arbiter.sv
// rtl/axicb_slv_wr_arbiter.sv - round-robin AW arbiter with in-order W and B routing for one slave
// AXICB_WRARB_PRIO0_EN: master 0 strictly preempts round-robin at every selection.
module axicb_slv_wr_arbiter #(
  parameter int MST_NB     = 4,
  parameter int AWCH_W     = 8,
  parameter int WCH_W      = 8,
  parameter int BCH_W      = 10,
  parameter int OSTD_DEPTH = 4
) (
  input logic                   aclk,
  input logic                   srst,
  axicb_slv_wr_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(MST_NB);
  localparam int PTR_W = $clog2(OSTD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, GRANT} aw_state_e;

  aw_state_e        state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             aw_hs;

  logic [IDX_W-1:0] wfifo_mem_q [OSTD_DEPTH];
  logic [PTR_W-1:0] wfifo_wr_q, wfifo_rd_q;
  logic [CNT_W-1:0] wfifo_cnt_q;
  logic [IDX_W-1:0] bfifo_mem_q [OSTD_DEPTH];
  logic [PTR_W-1:0] bfifo_wr_q, bfifo_rd_q;
  logic [CNT_W-1:0] bfifo_cnt_q;

  logic             wfifo_empty, wfifo_full, bfifo_empty, bfifo_full;
  logic [IDX_W-1:0] w_head, b_head;
  logic             w_pop, b_pop;
  logic [MST_NB-1:0] awready_v, wready_v, bvalid_v;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + (IDX_W+1)'(off);
    if (sum >= (IDX_W+1)'(MST_NB)) sum = sum - (IDX_W+1)'(MST_NB);
    return sum[IDX_W-1:0];
  endfunction

  assign wfifo_empty = (wfifo_cnt_q == '0);
  assign wfifo_full  = (wfifo_cnt_q == CNT_W'(OSTD_DEPTH));
  assign bfifo_empty = (bfifo_cnt_q == '0);
  assign bfifo_full  = (bfifo_cnt_q == CNT_W'(OSTD_DEPTH));
  assign w_head      = wfifo_mem_q[wfifo_rd_q];
  assign b_head      = bfifo_mem_q[bfifo_rd_q];

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < MST_NB; i++) begin
      if (!sel_found && bus.i_awvalid[wrap_add(rr_ptr_q, i)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_add(rr_ptr_q, i);
      end
    end
`ifdef AXICB_WRARB_PRIO0_EN
    if (bus.i_awvalid[0]) begin
      sel_found = 1'b1;
      sel_idx   = '0;
    end
`else
`endif
  end

  // Room in both FIFOs is checked at grant time, so the handshake can always push.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    aw_hs    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found && !wfifo_full && !bfifo_full) begin
          state_d = GRANT;
          grant_d = sel_idx;
        end
      end
      GRANT: begin
        if (bus.o_awready) begin
          aw_hs    = 1'b1;
          state_d  = IDLE;
          rr_ptr_d = wrap_add(grant_q, 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    awready_v = '0;
    wready_v  = '0;
    bvalid_v  = '0;
    if (state_q == GRANT) awready_v[grant_q] = bus.o_awready;
    if (!wfifo_empty)     wready_v[w_head]   = bus.o_wready;
    if (!bfifo_empty)     bvalid_v[b_head]   = bus.o_bvalid;
  end

  assign bus.o_awvalid = (state_q == GRANT);
  assign bus.o_awch    = bus.i_awch[grant_q*AWCH_W +: AWCH_W];
  assign bus.i_awready = awready_v;

  assign bus.o_wvalid  = !wfifo_empty && bus.i_wvalid[w_head];
  assign bus.o_wlast   = !wfifo_empty && bus.i_wlast[w_head];
  assign bus.o_wch     = bus.i_wch[w_head*WCH_W +: WCH_W];
  assign bus.i_wready  = wready_v;
  assign w_pop         = bus.o_wvalid && bus.o_wready && bus.o_wlast;

  assign bus.i_bvalid  = bvalid_v;
  assign bus.i_bch     = bus.o_bch;
  assign bus.o_bready  = !bfifo_empty && bus.i_bready[b_head];
  assign b_pop         = bus.o_bvalid && bus.o_bready;
  assign bus.o_ostd    = bfifo_cnt_q;

  always_ff @(posedge aclk) begin
    if (aw_hs) begin
      wfifo_mem_q[wfifo_wr_q] <= grant_q;
      bfifo_mem_q[bfifo_wr_q] <= grant_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      wfifo_wr_q  <= '0;
      wfifo_rd_q  <= '0;
      wfifo_cnt_q <= '0;
      bfifo_wr_q  <= '0;
      bfifo_rd_q  <= '0;
      bfifo_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      if (aw_hs) wfifo_wr_q <= wfifo_wr_q + 1'b1;
      if (w_pop) wfifo_rd_q <= wfifo_rd_q + 1'b1;
      if (aw_hs) bfifo_wr_q <= bfifo_wr_q + 1'b1;
      if (b_pop) bfifo_rd_q <= bfifo_rd_q + 1'b1;
      case ({aw_hs, w_pop})
        2'b10:   wfifo_cnt_q <= wfifo_cnt_q + 1'b1;
        2'b01:   wfifo_cnt_q <= wfifo_cnt_q - 1'b1;
        default: wfifo_cnt_q <= wfifo_cnt_q;
      endcase
      case ({aw_hs, b_pop})
        2'b10:   bfifo_cnt_q <= bfifo_cnt_q + 1'b1;
        2'b01:   bfifo_cnt_q <= bfifo_cnt_q - 1'b1;
        default: bfifo_cnt_q <= bfifo_cnt_q;
      endcase
    end
  end
endmodule

// File: tb/tb_axicb_slv_wr_arbiter.sv
// tb/tb_axicb_slv_wr_arbiter.sv - directed scoreboard bench for axicb_slv_wr_arbiter
// AW grants and W beats are predicted into queues and checked as the slave side accepts them.
module tb_axicb_slv_wr_arbiter;
  localparam int MST_NB = 4, AWCH_W = 8, WCH_W = 8, BCH_W = 10, OSTD_DEPTH = 4;

  logic aclk = 1'b0;
  logic srst = 1'b1;
  always #5 aclk = ~aclk;

  axicb_slv_wr_arbiter_if #(.MST_NB(MST_NB), .AWCH_W(AWCH_W), .WCH_W(WCH_W),
                            .BCH_W(BCH_W), .OSTD_DEPTH(OSTD_DEPTH)) bus ();

  axicb_slv_wr_arbiter #(.MST_NB(MST_NB), .AWCH_W(AWCH_W), .WCH_W(WCH_W),
                         .BCH_W(BCH_W), .OSTD_DEPTH(OSTD_DEPTH)) dut (
    .aclk(aclk), .srst(srst), .bus(bus));

  int tests = 0, fails = 0;
  int aw_seen = 0;
  int aw_q[$];
  int w_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (!srst && bus.o_awvalid && bus.o_awready) begin
      chk("aw_sb_nonempty", 32'(aw_q.size() != 0), 1);
      if (aw_q.size() != 0) begin
        int m;
        m = aw_q.pop_front();
        chk("aw_grant_payload", 32'(bus.o_awch), 32'(8'hA0 + m));
        chk("aw_ready_route", 32'(bus.i_awready), 32'(1 << m));
        aw_seen++;
      end
    end
    if (!srst && bus.o_wvalid && bus.o_wready) begin
      chk("w_sb_nonempty", 32'(w_q.size() != 0), 1);
      if (w_q.size() != 0) chk("w_beat_data", 32'(bus.o_wch), 32'(w_q.pop_front()));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic wait_aw(input int target, input int budget);
    int n = 0;
    while (aw_seen < target && n < budget) begin
      @(posedge aclk);
      n++;
    end
    #1;
    chk("aw_wait", 32'(aw_seen), 32'(target));
  endtask

  task automatic wait_w_empty(input int budget);
    int n = 0;
    while (w_q.size() != 0 && n < budget) begin
      @(posedge aclk);
      n++;
    end
    #1;
    chk("w_drain", 32'(w_q.size()), 0);
  endtask

  task automatic drain_b(input int budget);
    int n = 0;
    bus.o_bvalid = 1'b1;
    bus.i_bready = '1;
    while (bus.o_ostd != 0 && n < budget) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("b_drain_ostd", 32'(bus.o_ostd), 0);
    bus.o_bvalid = 1'b0;
  endtask

  task automatic wait_grant(input int budget);
    int n = 0;
    while (!bus.o_awvalid && n < budget) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("grant_wait", 32'(bus.o_awvalid), 1);
  endtask

  initial begin
    int base, n;
    bus.i_awvalid = '0; bus.i_awch = 32'hA3A2A1A0;
    bus.i_wvalid = '0;  bus.i_wlast = '1; bus.i_wch = 32'hC3C2C1C0;
    bus.i_bready = '0;  bus.o_awready = 1'b0; bus.o_wready = 1'b0;
    bus.o_bvalid = 1'b0; bus.o_bch = 10'h2A5;

    // reset state
    cyc(3);
    chk("rst_awvalid", 32'(bus.o_awvalid), 0);
    chk("rst_wvalid", 32'(bus.o_wvalid), 0);
    chk("rst_bready", 32'(bus.o_bready), 0);
    chk("rst_ostd", 32'(bus.o_ostd), 0);
    chk("rst_ready_valid", 32'({bus.i_awready, bus.i_wready, bus.i_bvalid}), 0);
    srst = 1'b0;
    cyc(1);

    // all masters requesting, single-beat W, slave always ready
    base = aw_seen;
    for (int r = 0; r < 2; r++)
      for (int m = 0; m < 4; m++) begin aw_q.push_back(m); w_q.push_back(8'hC0 + m); end
    bus.o_awready = 1'b1; bus.o_wready = 1'b1; bus.o_bvalid = 1'b1; bus.i_bready = '1;
    bus.i_wvalid = '1; bus.i_awvalid = '1;
    n = 0;
    while (aw_seen < base + 8 && n < 100) begin
      @(negedge aclk);
      chk("ostd_le1", 32'(bus.o_ostd <= 1), 1);
      @(posedge aclk);
      n++;
    end
    #1;
    bus.i_awvalid = '0;
    chk("rr_grants", 32'(aw_seen), 32'(base + 8));
    wait_w_empty(20);
    drain_b(20);
    chk("bch_broadcast", 32'(bus.i_bch), 32'h2A5);
    bus.i_wvalid = '0;

    // outstanding limit: master 1, B held off
    base = aw_seen;
    for (int k = 0; k < 5; k++) begin aw_q.push_back(1); w_q.push_back(8'hC1); end
    bus.o_bvalid = 1'b0; bus.i_bready = '0;
    bus.i_wvalid[1] = 1'b1; bus.i_awvalid[1] = 1'b1;
    wait_aw(base + 4, 100);
    cyc(8);
    chk("ostd_full_stall", 32'(aw_seen), 32'(base + 4));
    chk("ostd_full_cnt", 32'(bus.o_ostd), 4);
    chk("ostd_full_noaw", 32'(bus.o_awvalid), 0);
    bus.o_bvalid = 1'b1; bus.i_bready = 4'b0010;
    @(negedge aclk);
    chk("b_route_m1", 32'(bus.i_bvalid), 2);
    chk("b_bready_m1", 32'(bus.o_bready), 1);
    cyc(1);
    bus.o_bvalid = 1'b0;
    wait_aw(base + 5, 20);
    bus.i_awvalid[1] = 1'b0;
    chk("ostd_refill", 32'(bus.o_ostd), 4);
    wait_w_empty(20);
    bus.i_wvalid = '0;
    drain_b(20);

    // W ordering: master 2 four-beat burst precedes master 0 single beat
    bus.i_wvalid[0] = 1'b1;
    bus.i_awvalid[2] = 1'b1; aw_q.push_back(2);
    @(negedge aclk);
    chk("w_stall_pre_aw", 32'({bus.o_wvalid, bus.i_wready}), 0);
    base = aw_seen;
    wait_aw(base + 1, 20);
    bus.i_awvalid[2] = 1'b0;
    bus.i_awvalid[0] = 1'b1; aw_q.push_back(0);
    wait_aw(base + 2, 20);
    bus.i_awvalid[0] = 1'b0;
    chk("w_head_m2_idle", 32'(bus.o_wvalid), 0);
    chk("w_ready_m2", 32'(bus.i_wready), 4);
    for (int b = 0; b < 4; b++) w_q.push_back(8'h20 + b);
    w_q.push_back(8'hC0);
    for (int b = 0; b < 4; b++) begin
      bus.i_wvalid[2] = 1'b1;
      bus.i_wlast[2] = (b == 3);
      bus.i_wch[2*WCH_W +: WCH_W] = 8'(8'h20 + b);
      @(negedge aclk);
      chk("w_m0_stalled", 32'(bus.i_wready[0]), 0);
      cyc(1);
    end
    bus.i_wvalid[2] = 1'b0; bus.i_wlast[2] = 1'b1; bus.i_wch[2*WCH_W +: WCH_W] = 8'hC2;
    wait_w_empty(20);
    bus.i_wvalid = '0;
    drain_b(20);

    // simultaneous AW and B handshake at ostd 2
    bus.o_bvalid = 1'b0; bus.i_bready = '0;
    bus.i_wvalid[3] = 1'b1; bus.i_wvalid[1] = 1'b1;
    base = aw_seen;
    bus.i_awvalid[3] = 1'b1; aw_q.push_back(3); w_q.push_back(8'hC3);
    wait_aw(base + 1, 20);
    bus.i_awvalid[3] = 1'b0;
    bus.i_awvalid[1] = 1'b1; aw_q.push_back(1); w_q.push_back(8'hC1);
    wait_aw(base + 2, 20);
    bus.i_awvalid[1] = 1'b0;
    wait_w_empty(20);
    chk("ostd_two", 32'(bus.o_ostd), 2);
    bus.o_awready = 1'b0;
    bus.i_wvalid[0] = 1'b1; bus.i_awvalid[0] = 1'b1;
    aw_q.push_back(0); w_q.push_back(8'hC0);
    wait_grant(20);
    bus.o_awready = 1'b1; bus.o_bvalid = 1'b1; bus.i_bready = '1;
    #1;
    chk("b_route_head_m3", 32'(bus.i_bvalid), 8);
    chk("b_bready_head", 32'(bus.o_bready), 1);
    cyc(1);
    bus.i_awvalid[0] = 1'b0; bus.o_bvalid = 1'b0;
    chk("ostd_aw_b_same", 32'(bus.o_ostd), 2);
    bus.o_bvalid = 1'b1;
    #1;
    chk("b_route_next_m1", 32'(bus.i_bvalid), 2);
    bus.o_awready = 1'b1;
    wait_w_empty(20);
    bus.i_wvalid = '0;
    drain_b(20);

    // reset during an active grant for master 3
    bus.o_bvalid = 1'b0;
    base = aw_seen;
    bus.i_wvalid[2] = 1'b1; bus.i_awvalid[2] = 1'b1;
    aw_q.push_back(2); w_q.push_back(8'hC2);
    wait_aw(base + 1, 20);
    bus.i_awvalid[2] = 1'b0;
    wait_w_empty(20);
    chk("ostd_pre_rst", 32'(bus.o_ostd), 1);
    bus.o_awready = 1'b0; bus.i_wvalid = '0;
    bus.i_awvalid[3] = 1'b1;
    wait_grant(20);
    srst = 1'b1;
    cyc(1);
    chk("rst_mid_awvalid", 32'(bus.o_awvalid), 0);
    chk("rst_mid_ostd", 32'(bus.o_ostd), 0);
    chk("rst_mid_awready", 32'(bus.i_awready), 0);
    srst = 1'b0;
    bus.o_awready = 1'b1;
    bus.i_wvalid[1] = 1'b1; bus.i_wvalid[3] = 1'b1;
    bus.i_awvalid[1] = 1'b1;
    aw_q.push_back(1); aw_q.push_back(3);
    w_q.push_back(8'hC1); w_q.push_back(8'hC3);
    base = aw_seen;
    wait_aw(base + 1, 20);
    bus.i_awvalid[1] = 1'b0;
    wait_aw(base + 2, 20);
    bus.i_awvalid[3] = 1'b0;
    wait_w_empty(20);
    bus.i_wvalid = '0;
    drain_b(20);

    // masters 0 and 2 contending
    base = aw_seen;
    for (int k = 0; k < 4; k++) begin
`ifdef AXICB_WRARB_PRIO0_EN
      aw_q.push_back(0); w_q.push_back(8'hC0);
`else
      aw_q.push_back((k % 2) * 2); w_q.push_back(8'hC0 + (k % 2) * 2);
`endif
    end
    bus.o_bvalid = 1'b1; bus.i_bready = '1;
    bus.i_wvalid = 4'b0101;
    bus.i_awvalid = 4'b0101;
    wait_aw(base + 4, 40);
    bus.i_awvalid = '0;
    wait_w_empty(20);
    bus.i_wvalid = '0;
    drain_b(20);

    cyc(3);
    chk("aw_sb_empty", 32'(aw_q.size()), 0);
    chk("final_ostd", 32'(bus.o_ostd), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axicb_slv_wr_arbiter.md
AXICB_SLV_WR_ARBITER -- requirements
Module: axicb_slv_wr_arbiter

Interface
REQ-001 Parameter MST_NB, 4, number of master ports sharing one slave write path (2..8).
REQ-002 Parameter AWCH_W, 8, concatenated AW channel width.
REQ-003 Parameter WCH_W, 8, concatenated W channel width.
REQ-004 Parameter BCH_W, 10, concatenated B channel width.
REQ-005 Parameter OSTD_DEPTH, 4, max outstanding writes; power of two, 2..256.
REQ-006 aclk  in  1  single clock; all logic rising-edge.
REQ-007 srst  in  1  reset, synchronous, active-high; no other reset.
REQ-008 i_awvalid / i_awready  in / out  MST_NB  per-master AW handshake.
REQ-009 i_awch  in  MST_NB*AWCH_W  per-master AW payload, master k at [k*AWCH_W+:AWCH_W].
REQ-010 i_wvalid, i_wlast / i_wready  in / out  MST_NB  per-master W handshake.
REQ-011 i_wch  in  MST_NB*WCH_W  per-master W payload.
REQ-012 i_bvalid / i_bready  out / in  MST_NB  per-master B handshake.
REQ-013 i_bch  out  BCH_W  B payload, broadcast to all masters.
REQ-014 o_awvalid, o_awch / o_awready  out / in  1, AWCH_W / 1  slave AW.
REQ-015 o_wvalid, o_wlast, o_wch / o_wready  out / in  1, 1, WCH_W / 1  slave W.
REQ-016 o_bvalid, o_bch / o_bready  in / out  1, BCH_W / 1  slave B.
REQ-017 o_ostd  out  $clog2(OSTD_DEPTH)+1  current outstanding write count.

Function
REQ-018 AW FSM states IDLE, GRANT; IDLE->GRANT when any i_awvalid set, wfifo not full, bfifo not full; grant registered (1-cycle latency request->o_awvalid).
REQ-019 In GRANT, o_awvalid=1 and o_awch=granted payload; grant held unchanged until o_awvalid&o_awready; only granted master sees i_awready=o_awready.
REQ-020 On AW handshake: push granted index into wfifo and bfifo, rotate RR pointer to granted+1 (mod MST_NB), return to IDLE; back-to-back grants have one idle cycle.
REQ-021 RR selection: first requester at or after pointer, wrapping; pointer resets to 0.
REQ-022 Push blocked when a FIFO is full, even if same-cycle pop occurs; no new grant while full.
REQ-023 W routing from wfifo head: o_wvalid=i_wvalid[head], i_wready[head]=o_wready, other i_wready=0; wfifo empty -> o_wvalid=0, all i_wready=0.
REQ-024 wfifo pops on o_wvalid&o_wready&o_wlast; next burst routed from following cycle.
REQ-025 B routing from bfifo head (slave returns B in AW order): i_bvalid[head]=o_bvalid, o_bready=i_bready[head]; bfifo empty -> o_bready=0, all i_bvalid=0.
REQ-026 bfifo pops on B handshake; o_ostd = bfifo occupancy, +1 on AW handshake, -1 on B handshake, unchanged when both same cycle.
REQ-027 W may complete before or after AW handshake on slave side; W before own AW grant is stalled (not routed).

Reset
REQ-028 srst forces FSM IDLE, pointer 0, both FIFOs empty, o_ostd 0, o_awvalid 0, o_wvalid 0, o_bready 0, all i_awready/i_wready/i_bvalid 0 next cycle.
REQ-029 srst mid-transaction drops in-flight grant and bookkeeping without completion.

Configuration
REQ-030 Macro AXICB_WRARB_PRIO0_EN: defined -> master 0 strictly preempts RR at each IDLE selection (pointer still advances after grant); undefined -> pure RR.

Verification
REQ-031 MST_NB=4, all masters request continuously, single-beat W, slave always ready -> grants 0,1,2,3,0 repeating; o_ostd never exceeds 1 beyond pipeline.
REQ-032 Slave o_bvalid held 0, master 1 issues 5 AWs, OSTD_DEPTH=4 -> 4 accepted, 5th stalled, o_ostd=4; one B -> 5th accepted, o_ostd stays 4.
REQ-033 Master 2 AW len 3 (4 beats) then master 0 AW; master 0 W presented first -> master 0 W stalled until master 2 wlast beat accepted.
REQ-034 Simultaneous AW and B handshake with o_ostd=2 -> o_ostd remains 2; B routed to head-of-bfifo master only.
REQ-035 srst asserted while GRANT active for master 3 -> next cycle o_awvalid=0, o_ostd=0, pointer 0; next request from master 3 re-granted.
REQ-036 With AXICB_WRARB_PRIO0_EN, masters 0 and 2 requesting continuously -> master 0 granted every time; without macro -> alternating 0,2.
